// File: rtl/cam_pkg.sv
// cam_pkg: shared types and constants for the camera capture controller.
package cam_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_VS_HI,
    WAIT_VS_LO,
    WAIT_HREF,
    LINE,
    FRAME_END
  } cam_state_t;

  localparam int unsigned CAM_HOR_NUM_DEF = 800;
  localparam int unsigned CAM_VER_NUM_DEF = 480;
  localparam int unsigned PIX_CNT_W       = 11;
  localparam int unsigned LINE_CNT_W      = 10;
  localparam int unsigned BYTE_W          = 8;
  localparam int unsigned PIX_W           = 16;

endpackage

// File: rtl/cam_byte_pack.sv
// cam_byte_pack: tracks the high/low byte phase of the camera bus and
// assembles 16-bit pixels, strobing when the low byte arrives.
// CAM_LINE_CHECK_EN exposes the pending-odd-byte flag for line checking.
module cam_byte_pack
  import cam_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_clr,
  input  logic [BYTE_W-1:0] i_data,
  output logic              o_pix_stb,
  output logic [PIX_W-1:0]  o_pix_data
`ifdef CAM_LINE_CHECK_EN
  ,
  output logic              o_odd
`endif
);

  logic              r_phase_lo;
  logic [BYTE_W-1:0] r_hi;

  // Byte phase and high-byte capture; clear returns to expecting a high byte
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_phase_lo <= 1'b0;
      r_hi       <= '0;
    end else if (i_clr) begin
      r_phase_lo <= 1'b0;
    end else if (i_en) begin
      if (!r_phase_lo) r_hi <= i_data;
      r_phase_lo <= ~r_phase_lo;
    end
  end

  // Pixel completes combinationally with the low byte; the top registers it
  always_comb begin
    o_pix_stb  = i_en & ~i_clr & r_phase_lo;
    o_pix_data = {r_hi, i_data};
  end

`ifdef CAM_LINE_CHECK_EN
  assign o_odd = r_phase_lo;
`endif

endmodule

// File: rtl/cam_capture_ctrl.sv
// cam_capture_ctrl: frame-synchronous camera capture into a single
// RGB565 holding register with sticky overflow/line errors.
// Optional macro CAM_LINE_CHECK_EN adds line-length and odd-byte checks.
module cam_capture_ctrl
  import cam_pkg::*;
#(
  parameter int HOR_NUM = CAM_HOR_NUM_DEF,
  parameter int VER_NUM = CAM_VER_NUM_DEF
) (
  input  logic              cmos_pclk,
  input  logic              rst_n,
  input  logic [BYTE_W-1:0] cmos_data,
  input  logic              cmos_href,
  input  logic              cmos_vsyn,
  input  logic              cap_start,
  input  logic              cap_cont,
  input  logic              cap_stop,
  input  logic              err_clr,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_sof,
  output logic              pix_eol,
  output logic              busy,
  output logic              frame_done,
  output logic [15:0]       frame_cnt,
  output logic              err_ovf,
  output logic              err_line
);

  localparam logic [PIX_CNT_W-1:0]  LP_PIX_LAST  = PIX_CNT_W'(HOR_NUM - 1);
  localparam logic [PIX_CNT_W-1:0]  LP_PIX_NUM   = PIX_CNT_W'(HOR_NUM);
  localparam logic [LINE_CNT_W-1:0] LP_LINE_LAST = LINE_CNT_W'(VER_NUM - 1);

  cam_state_t            r_state, w_next;
  logic [PIX_CNT_W-1:0]  r_pix_cnt;
  logic [LINE_CNT_W-1:0] r_line_cnt;
  logic [PIX_W-1:0]      r_pix_data;
  logic                  r_pix_valid, r_pix_sof, r_pix_eol;
  logic [15:0]           r_frame_cnt;
  logic                  r_err_ovf, r_err_line;

  logic                  w_cap_en, w_clr, w_pix_stb, w_pix_ok, w_xfer;
  logic                  w_abort, w_href_fall, w_enter_vs_lo, w_line_err;
  logic [PIX_W-1:0]      w_pix_word;

  assign w_cap_en      = (r_state == WAIT_HREF || r_state == LINE) && cmos_href && !cmos_vsyn;
  assign w_clr         = cap_stop | ~w_cap_en;
  assign w_abort       = !cap_stop && (r_state == WAIT_HREF || r_state == LINE) && cmos_vsyn;
  assign w_href_fall   = !cap_stop && (r_state == LINE) && !cmos_href && !cmos_vsyn;
  assign w_enter_vs_lo = (w_next == WAIT_VS_LO) && (r_state != WAIT_VS_LO);
  assign w_pix_ok      = w_pix_stb && (r_pix_cnt <= LP_PIX_LAST);
  assign w_xfer        = r_pix_valid & pix_ready;

`ifdef CAM_LINE_CHECK_EN
  logic w_odd;
`endif

  cam_byte_pack u_pack (
    .i_clk      (cmos_pclk),
    .i_rst_n    (rst_n),
    .i_en       (w_cap_en),
    .i_clr      (w_clr),
    .i_data     (cmos_data),
    .o_pix_stb  (w_pix_stb),
    .o_pix_data (w_pix_word)
`ifdef CAM_LINE_CHECK_EN
    ,
    .o_odd      (w_odd)
`endif
  );

  // State register
  always_ff @(posedge cmos_pclk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; cap_stop overrides everything, vsync aborts an active frame
  always_comb begin
    w_next = r_state;
    if (cap_stop) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:       if (cap_start)  w_next = WAIT_VS_HI;
        WAIT_VS_HI: if (cmos_vsyn)  w_next = WAIT_VS_LO;
        WAIT_VS_LO: if (!cmos_vsyn) w_next = WAIT_HREF;
        WAIT_HREF: begin
          if (cmos_vsyn)      w_next = WAIT_VS_LO;
          else if (cmos_href) w_next = LINE;
        end
        LINE: begin
          if (cmos_vsyn)       w_next = WAIT_VS_LO;
          else if (!cmos_href) w_next = (r_line_cnt == LP_LINE_LAST) ? FRAME_END : WAIT_HREF;
        end
        FRAME_END:  w_next = cap_cont ? WAIT_VS_HI : IDLE;
        default:    w_next = IDLE;
      endcase
    end
  end

  // State-decoded outputs
  always_comb begin
    busy       = (r_state != IDLE);
    frame_done = (r_state == FRAME_END);
  end

  // Pixel and line counters; pixel counter saturates so overlong lines stay detectable
  always_ff @(posedge cmos_pclk) begin
    if (!rst_n || cap_stop) begin
      r_pix_cnt  <= '0;
      r_line_cnt <= '0;
    end else if (w_enter_vs_lo) begin
      r_pix_cnt  <= '0;
      r_line_cnt <= '0;
    end else if (w_href_fall) begin
      r_pix_cnt  <= '0;
      r_line_cnt <= (r_line_cnt == LP_LINE_LAST) ? '0 : r_line_cnt + 1'b1;
    end else if (w_pix_stb && r_pix_cnt != '1) begin
      r_pix_cnt  <= r_pix_cnt + 1'b1;
    end
  end

  // Single holding register: reload when empty or draining this cycle, else drop
  always_ff @(posedge cmos_pclk) begin
    if (!rst_n) begin
      r_pix_data  <= '0;
      r_pix_valid <= 1'b0;
      r_pix_sof   <= 1'b0;
      r_pix_eol   <= 1'b0;
    end else if (cap_stop) begin
      r_pix_valid <= 1'b0;
      r_pix_sof   <= 1'b0;
      r_pix_eol   <= 1'b0;
    end else if (w_pix_ok && (!r_pix_valid || w_xfer)) begin
      r_pix_data  <= w_pix_word;
      r_pix_valid <= 1'b1;
      r_pix_sof   <= (r_pix_cnt == '0) && (r_line_cnt == '0);
      r_pix_eol   <= (r_pix_cnt == LP_PIX_LAST);
    end else if (w_xfer) begin
      r_pix_valid <= 1'b0;
      r_pix_sof   <= 1'b0;
      r_pix_eol   <= 1'b0;
    end
  end

  // Line error sources; length/odd-byte checks only in the checking build
  always_comb begin
    w_line_err = w_abort;
`ifdef CAM_LINE_CHECK_EN
    if (w_href_fall && (r_pix_cnt != LP_PIX_NUM || w_odd)) w_line_err = 1'b1;
`endif
  end

  // Sticky errors (new error beats clear) and completed-frame counter
  always_ff @(posedge cmos_pclk) begin
    if (!rst_n) begin
      r_err_ovf   <= 1'b0;
      r_err_line  <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_err_ovf  <= (r_err_ovf  & ~err_clr) | (w_pix_ok && r_pix_valid && !pix_ready);
      r_err_line <= (r_err_line & ~err_clr) | w_line_err;
      if (r_state == FRAME_END) r_frame_cnt <= r_frame_cnt + 1'b1;
    end
  end

  assign pix_data  = r_pix_data;
  assign pix_valid = r_pix_valid;
  assign pix_sof   = r_pix_sof;
  assign pix_eol   = r_pix_eol;
  assign frame_cnt = r_frame_cnt;
  assign err_ovf   = r_err_ovf;
  assign err_line  = r_err_line;

endmodule

// File: doc/cam_capture_ctrl.md
CAM_CAPTURE_CTRL -- requirements
Module: cam_capture_ctrl

Interface
REQ-001 Parameter HOR_NUM, default 800, pixels per line.
REQ-002 Parameter VER_NUM, default 480, lines per frame.
REQ-003 cmos_pclk  in  1  sole clock; all logic on posedge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 cmos_data  in  8  camera byte, high byte first per pixel.
REQ-006 cmos_href  in  1  line-active qualifier.
REQ-007 cmos_vsyn  in  1  frame sync, high = blanking.
REQ-008 cap_start  in  1  one-cycle pulse: arm capture.
REQ-009 cap_cont  in  1  1 = re-arm after each frame; 0 = single frame.
REQ-010 cap_stop  in  1  one-cycle pulse: abort to IDLE.
REQ-011 err_clr  in  1  one-cycle pulse: clear sticky errors.
REQ-012 pix_data  out  16  assembled RGB565 pixel.
REQ-013 pix_valid  out  1  pixel held; pix_sof, pix_eol qualify it.
REQ-014 pix_ready  in  1  downstream accept; transfer = pix_valid & pix_ready.
REQ-015 pix_sof  out  1  first pixel of frame; pix_eol  out  1  last pixel of line.
REQ-016 busy  out  1  state != IDLE; frame_done  out  1  one-cycle pulse.
REQ-017 frame_cnt  out  16  completed frames, wraps at 16'hFFFF.
REQ-018 err_ovf  out  1  sticky overflow; err_line  out  1  sticky line-length error.

Function
REQ-019 States: IDLE, WAIT_VS_HI, WAIT_VS_LO, WAIT_HREF, LINE, FRAME_END.
REQ-020 IDLE -> WAIT_VS_HI on cap_start; cap_start ignored when not IDLE.
REQ-021 WAIT_VS_HI -> WAIT_VS_LO when cmos_vsyn=1; WAIT_VS_LO -> WAIT_HREF when cmos_vsyn=0 (capture starts only at a full frame boundary).
REQ-022 WAIT_HREF -> LINE when cmos_href=1; that byte is captured as high byte of pixel 0.
REQ-023 In LINE, bytes alternate high/low; pixel complete on low byte; pix_valid asserts the cycle after the low byte is sampled (latency 1).
REQ-024 LINE -> WAIT_HREF when cmos_href falls and line counter < VER_NUM-1; -> FRAME_END when it falls on line VER_NUM-1.
REQ-025 FRAME_END: pulse frame_done, frame_cnt+1; -> WAIT_VS_HI if cap_cont=1, else IDLE.
REQ-026 Pixel counter 11 bits, line counter 10 bits; both clear on entry to WAIT_VS_LO.
REQ-027 pix_eol set on pixel HOR_NUM-1; pix_sof set on pixel 0 of line 0.
REQ-028 Pixels past HOR_NUM-1 in a line are dropped, not presented.
REQ-029 Odd trailing byte at href fall is discarded.
REQ-030 Output is a single holding register; camera is never stalled.
REQ-031 New pixel completing while pix_valid=1 and pix_ready=0: new pixel dropped, held pixel kept, err_ovf set.
REQ-032 New pixel completing in the same cycle as a transfer: register reloads, no error.
REQ-033 cmos_vsyn=1 while in WAIT_HREF or LINE: abort frame, no frame_done, err_line set, -> WAIT_VS_LO.
REQ-034 cap_stop: -> IDLE next cycle from any state, pix_valid cleared, counters cleared, frame_cnt kept.
REQ-035 err_clr clears sticky errors; a simultaneous new error wins.

Reset
REQ-036 On rst_n=0 at posedge: state IDLE, pix_data 0, pix_valid/pix_sof/pix_eol 0, busy 0, frame_done 0, frame_cnt 0, err_ovf 0, err_line 0, byte phase high, all counters 0.
REQ-037 Reset mid-line discards partial pixel; capture resumes only after new cap_start.

Configuration
REQ-038 Macro CAM_LINE_CHECK_EN defined: href fall with pixel count != HOR_NUM, or an odd trailing byte, sets err_line.
REQ-039 Macro undefined: length and odd-byte checks absent; err_line set only per REQ-033.

Structure
REQ-040 Package cam_pkg holds state enum, default HOR_NUM/VER_NUM, counter width constants.
REQ-041 Sub-module cam_byte_pack: byte-phase tracking and 16-bit assembly, emits pixel strobe.

Verification
REQ-042 cap_start, cap_cont=0, 800x480 frame of data counting up from 16'h8000, pix_ready=1 -> 384000 pixels, first 16'h8000 with pix_sof, every 800th with pix_eol, one frame_done, frame_cnt=1, state IDLE.
REQ-043 pix_ready=0 for 4 cycles mid-line -> err_ovf=1, held pixel unchanged, next accepted pixel equals the first pixel completed after pix_ready rises.
REQ-044 Line of 799 pixels, CAM_LINE_CHECK_EN defined -> err_line=1; undefined -> err_line=0.
REQ-045 cmos_vsyn forced high on line 200 -> no frame_done, err_line=1, next full frame captured with frame_cnt=1.
REQ-046 cap_cont=1 over 3 frames -> frame_cnt=3; cap_stop mid-frame -> IDLE next cycle, pix_valid=0.
REQ-047 rst_n low mid-line -> all outputs at reset values next cycle; capture resumes only after cap_start.
